// File: rtl/spi_rescue_pkg.sv
// SPI NOR power-loss rescue sequencer: shared state type, constants and
// helpers for frame sequencing and per-frame pad setup.
package spi_rescue_pkg;

    typedef enum logic [3:0] {
        IDLE, P1Q, P1D, P1E, P2, GAP, POLL_CMD, POLL_RD, DONE
    } st_e;

    localparam logic [7:0] FSR_CMD       = 8'h70;
    localparam int         FSR_READY_BIT = 7;
    localparam int         MASK_QUAD     = 2;
    localparam int         MASK_DUAL     = 1;
    localparam int         MASK_EXT      = 0;

    // Next frame after state s; masked part-1 frames are skipped outright.
    function automatic st_e next_frame(input st_e s, input logic [2:0] m);
        if (s == IDLE && m[MASK_QUAD])
            return P1Q;
        if ((s == IDLE || s == P1Q) && m[MASK_DUAL])
            return P1D;
        if (s != P1E && s != P2 && m[MASK_EXT])
            return P1E;
        if (s != P2)
            return P2;
`ifdef SPI_RESCUE_FSR_POLL_EN
        return POLL_CMD;
`else
        return DONE;
`endif
    endfunction

    function automatic logic [3:0] frame_oe(input st_e s);
        return (s == POLL_CMD) ? 4'b0001 : 4'hF;
    endfunction

    // Poll command presents its MSB before the first SCK rise.
    function automatic logic [3:0] frame_dq(input st_e s);
        return (s == POLL_CMD) ? {3'b000, FSR_CMD[7]} : 4'hF;
    endfunction

endpackage

// File: rtl/spi_rescue_sck_gen.sv
// Mode-0 SCK divider for the rescue sequencer. Ports: clk_i/rst_i, en (run),
// clr (idle low, restart), cyc_clr (zero cycle count only); sck, rise/fall
// strobes (edge happens at the next clk edge), ncyc (completed SCK cycles).
module spi_rescue_sck_gen #(
    parameter int CLK_DIV = 2,
    parameter int CW      = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en,
    input  logic          clr,
    input  logic          cyc_clr,
    output logic          sck,
    output logic          rise,
    output logic          fall,
    output logic [CW-1:0] ncyc
);
    localparam int DW = $clog2(CLK_DIV + 1);

    logic [DW-1:0] div;
    logic          tick;

    assign tick = en && (div == DW'(CLK_DIV - 1));
    assign rise = tick && !sck;
    assign fall = tick && sck;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div  <= '0;
            sck  <= 1'b0;
            ncyc <= '0;
        end else if (clr) begin
            div  <= '0;
            sck  <= 1'b0;
            ncyc <= '0;
        end else if (en) begin
            div <= tick ? '0 : div + 1'b1;
            if (tick)
                sck <= !sck;
            if (cyc_clr)
                ncyc <= '0;
            else if (fall)
                ncyc <= ncyc + 1'b1;
        end
    end

endmodule

// File: rtl/spi_flash_rescue_seq.sv
// SPI NOR power-loss rescue sequencer: part-1 quad/dual/ext frames, part-2
// frame, optional FSR (0x70) poll when SPI_RESCUE_FSR_POLL_EN is defined.
// Ports: clk_i, rst_i, start_i, mask_i, abort_i; busy_o, done_o, error_o;
// SPI pads sck_o, cs_no, dq_o, dq_oe_o, dq_i; fsr_o last FSR read.
module spi_flash_rescue_seq
    import spi_rescue_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int QUAD_CYC  = 7,
    parameter int DUAL_CYC  = 13,
    parameter int EXT_CYC   = 17,
    parameter int P2_CYC    = 8,
    parameter int GAP_CYC   = 4,
    parameter int MAX_POLLS = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [2:0] mask_i,
    input  logic       abort_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o,
    output logic       sck_o,
    output logic       cs_no,
    output logic [3:0] dq_o,
    output logic [3:0] dq_oe_o,
    input  logic [3:0] dq_i,
    output logic [7:0] fsr_o
);
    localparam int M1 = (EXT_CYC > P2_CYC) ? EXT_CYC : P2_CYC;
    localparam int M2 = (M1 > 8) ? M1 : 8;
    localparam int M3 = (QUAD_CYC > M2) ? QUAD_CYC : M2;
    localparam int M4 = (DUAL_CYC > M3) ? DUAL_CYC : M3;
    localparam int CW = $clog2(M4 + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    st_e           state, nxt;
    logic [GW-1:0] gcnt;
    logic [2:0]    mask_q;
    logic [CW-1:0] ncyc, target;
    logic          rise, fall, fstate, fend, cyc_clr;

    assign fstate = (state == P1Q) || (state == P1D) || (state == P1E) ||
                    (state == P2) || (state == POLL_CMD) || (state == POLL_RD);
    // A frame ends on the would-be rise after its last SCK cycle.
    assign fend    = fstate && rise && (ncyc == target);
    // Command and read halves share one SCK burst; only the count restarts.
    assign cyc_clr = (state == POLL_CMD) && fall && (ncyc == CW'(7));

    always_comb begin
        target = CW'(8);
        unique case (state)
            P1Q:     target = CW'(QUAD_CYC);
            P1D:     target = CW'(DUAL_CYC);
            P1E:     target = CW'(EXT_CYC);
            P2:      target = CW'(P2_CYC);
            default: ;
        endcase
    end

    spi_rescue_sck_gen #(.CLK_DIV(CLK_DIV), .CW(CW)) u_sck (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en      (fstate),
        .clr     (!fstate || fend || abort_i),
        .cyc_clr (cyc_clr),
        .sck     (sck_o),
        .rise    (rise),
        .fall    (fall),
        .ncyc    (ncyc)
    );

`ifdef SPI_RESCUE_FSR_POLL_EN
    localparam int PW = $clog2(MAX_POLLS + 1);
    logic [7:0]    sh, rd;
    logic [PW-1:0] npoll;
    logic          unused_dq;
    assign unused_dq = ^{dq_i[3:2], dq_i[0]};
`else
    logic unused_cfg;
    assign unused_cfg = ^dq_i ^ (MAX_POLLS > 0);
    assign error_o    = 1'b0;
    assign fsr_o      = 8'h00;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            nxt     <= IDLE;
            gcnt    <= '0;
            mask_q  <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            cs_no   <= 1'b1;
            dq_o    <= '0;
            dq_oe_o <= '0;
`ifdef SPI_RESCUE_FSR_POLL_EN
            error_o <= 1'b0;
            fsr_o   <= '0;
            sh      <= '0;
            rd      <= '0;
            npoll   <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            if (abort_i) begin
                state   <= IDLE;
                busy_o  <= 1'b0;
                cs_no   <= 1'b1;
                dq_o    <= '0;
                dq_oe_o <= '0;
            end else begin
                unique case (state)
                    IDLE: if (start_i) begin
                        mask_q  <= mask_i;
                        busy_o  <= 1'b1;
                        state   <= next_frame(IDLE, mask_i);
                        cs_no   <= 1'b0;
                        dq_oe_o <= 4'hF;
                        dq_o    <= 4'hF;
`ifdef SPI_RESCUE_FSR_POLL_EN
                        error_o <= 1'b0;
                        npoll   <= '0;
`endif
                    end
                    P1Q, P1D, P1E, P2: if (fend) begin
                        state   <= GAP;
                        nxt     <= next_frame(state, mask_q);
                        gcnt    <= '0;
                        cs_no   <= 1'b1;
                        dq_o    <= '0;
                        dq_oe_o <= '0;
                    end
                    GAP: if (gcnt == GW'(GAP_CYC - 1)) begin
                        if (nxt == DONE) begin
                            state <= DONE;
                        end else begin
                            state   <= nxt;
                            cs_no   <= 1'b0;
                            dq_oe_o <= frame_oe(nxt);
                            dq_o    <= frame_dq(nxt);
`ifdef SPI_RESCUE_FSR_POLL_EN
                            sh <= {FSR_CMD[6:0], 1'b0};
                            rd <= '0;
`endif
                        end
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
`ifdef SPI_RESCUE_FSR_POLL_EN
                    POLL_CMD: if (fall) begin
                        dq_o <= {3'b000, sh[7]};
                        sh   <= {sh[6:0], 1'b0};
                        if (ncyc == CW'(7)) begin
                            state   <= POLL_RD;
                            dq_oe_o <= '0;
                            dq_o    <= '0;
                        end
                    end
                    POLL_RD: if (fend) begin
                        fsr_o <= rd;
                        cs_no <= 1'b1;
                        npoll <= npoll + 1'b1;
                        if (rd[FSR_READY_BIT]) begin
                            state <= GAP;
                            nxt   <= DONE;
                            gcnt  <= '0;
                        end else if (npoll == PW'(MAX_POLLS - 1)) begin
                            state   <= IDLE;
                            busy_o  <= 1'b0;
                            error_o <= 1'b1;
                        end else begin
                            state <= GAP;
                            nxt   <= POLL_CMD;
                            gcnt  <= '0;
                        end
                    end else if (rise) begin
                        rd <= {rd[6:0], dq_i[1]};
                    end
`endif
                    DONE: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_rescue_seq.sv
// Directed bench for spi_flash_rescue_seq: frame lengths, SCK counts, gaps,
// done/abort/reset behaviour and, in the poll build, FSR polling.
module tb_spi_flash_rescue_seq;

`ifdef SPI_RESCUE_FSR_POLL_EN
    localparam int POLLX = 1;
`else
    localparam int POLLX = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_i, start_i, abort_i;
    logic [2:0] mask_i;
    logic       busy_o, done_o, error_o, sck_o, cs_no;
    logic [3:0] dq_o, dq_oe_o, dq_i;
    logic [7:0] fsr_o;

    always #5 clk = ~clk;

    spi_flash_rescue_seq #(.MAX_POLLS(4)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .mask_i  (mask_i),
        .abort_i (abort_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .error_o (error_o),
        .sck_o   (sck_o),
        .cs_no   (cs_no),
        .dq_o    (dq_o),
        .dq_oe_o (dq_oe_o),
        .dq_i    (dq_i),
        .fsr_o   (fsr_o)
    );

    int vec = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int len;
        int rises;
        int nbad;
        int cmd;
    } frame_t;

    frame_t     frames[$];
    int         gaps[$];
    logic [7:0] resp[$];
    int         ndone, ridx, low_len, nrise, nbad, hi_len;
    logic       sck_q, cs_q, seen_low;
    logic [7:0] cmd, rv;

    function automatic frame_t fr(input int i);
        frame_t z = '{0, 0, 0, 0};
        if (i < frames.size())
            return frames[i];
        return z;
    endfunction

    task automatic clear_mon();
        frames.delete();
        gaps.delete();
        ndone    = 0;
        ridx     = 0;
        seen_low = 1'b0;
    endtask

    // Frame monitor plus a minimal flash model answering FSR reads on DQ1.
    initial begin
        sck_q = 1'b0; cs_q = 1'b1; hi_len = 0; dq_i = '0;
        low_len = 0; nrise = 0; nbad = 0; cmd = '0;
        clear_mon();
        forever begin
            @(negedge clk);
            if (done_o)
                ndone++;
            if (!cs_no) begin
                if (cs_q) begin
                    if (seen_low)
                        gaps.push_back(hi_len);
                    low_len = 0; nrise = 0; nbad = 0; cmd = '0;
                end
                low_len++;
                if (!(dq_oe_o == 4'hF && dq_o == 4'hF))
                    nbad++;
                if (sck_o && !sck_q) begin
                    nrise++;
                    if (nrise <= 8)
                        cmd = {cmd[6:0], dq_o[0]};
                end
                if (!sck_o && sck_q && nrise >= 8 && nrise < 16) begin
                    rv = 8'h00;
                    if (resp.size() > 0)
                        rv = (ridx < resp.size()) ? resp[ridx] : resp[$];
                    dq_i[1] = rv[15-nrise];
                end
            end else begin
                if (!cs_q) begin
                    frames.push_back('{low_len, nrise, nbad, int'(cmd)});
                    seen_low = 1'b1;
                    if (nrise > 8)
                        ridx++;
                    dq_i = '0;
                    hi_len = 1;
                end else begin
                    hi_len++;
                end
            end
            sck_q = sck_o;
            cs_q  = cs_no;
        end
    end

    task automatic start_seq(input logic [2:0] m);
        mask_i  = m;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 5000) begin
            @(posedge clk);
            #1 n++;
        end
        check(tag, n < 5000, 1'b1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    int n1[4] = '{7, 13, 17, 8};

    initial begin
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; mask_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", {busy_o, done_o, error_o, sck_o, cs_no}, 5'b00001);
        check("rst_dq", {dq_o, dq_oe_o}, 8'h00);
        check("rst_fsr", fsr_o, 8'h00);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // All part-1 modes enabled.
        resp = '{8'h80};
        clear_mon();
        start_seq(3'b111);
        check("t1_busy", busy_o, 1'b1);
        check("t1_cs_fall", cs_no, 1'b0);
        wait_idle("t1_idle");
        check("t1_nframes", frames.size(), 4 + POLLX);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_rise%0d", i), fr(i).rises, n1[i]);
            check($sformatf("t1_len%0d", i), fr(i).len, 4 * n1[i] + 2);
            check($sformatf("t1_dq%0d", i), fr(i).nbad, 0);
        end
        check("t1_ngaps", gaps.size(), 3 + POLLX);
        foreach (gaps[i])
            check($sformatf("t1_gap%0d", i), gaps[i], 4);
        check("t1_done", ndone, 1);

        // Dual only.
        resp = '{8'h80};
        clear_mon();
        start_seq(3'b010);
        wait_idle("t2_idle");
        check("t2_nframes", frames.size(), 2 + POLLX);
        check("t2_rise0", fr(0).rises, 13);
        check("t2_len0", fr(0).len, 54);
        check("t2_rise1", fr(1).rises, 8);
        check("t2_len1", fr(1).len, 34);
        check("t2_dq", fr(0).nbad + fr(1).nbad, 0);
        check("t2_done", ndone, 1);

        // Abort 10 clk into the extended frame.
        clear_mon();
        start_seq(3'b001);
        repeat (9) @(posedge clk);
        #1 abort_i = 1'b1;
        @(posedge clk);
        #1 abort_i = 1'b0;
        check("t5_pads", {cs_no, sck_o, dq_oe_o}, 6'b100000);
        check("t5_busy", busy_o, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("t5_len", fr(0).len, 10);
        check("t5_rise", fr(0).rises, 2);
        check("t5_done", ndone, 0);
        check("t5_err", error_o, 1'b0);

        // Start and abort together in idle: abort wins.
        abort_i = 1'b1;
        start_seq(3'b111);
        abort_i = 1'b0;
        check("t5_sa_busy", busy_o, 1'b0);
        check("t5_sa_cs", cs_no, 1'b1);

        // Async reset during part 2, then part 2 only.
        resp = '{8'h80};
        clear_mon();
        start_seq(3'b000);
        repeat (10) @(posedge clk);
        #3 rst_i = 1'b1;
        #1;
        check("t6_rst_ctl", {busy_o, done_o, sck_o, cs_no}, 4'b0001);
        check("t6_rst_dq", {dq_o, dq_oe_o}, 8'h00);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(posedge clk);
        #1;
        clear_mon();
        start_seq(3'b000);
        wait_idle("t6_idle");
        check("t6_nframes", frames.size(), 1 + POLLX);
        check("t6_rise", fr(0).rises, 8);
        check("t6_len", fr(0).len, 34);
        check("t6_done", ndone, 1);

`ifdef SPI_RESCUE_FSR_POLL_EN
        // FSR ready on the third read.
        resp = '{8'h00, 8'h00, 8'h80};
        clear_mon();
        start_seq(3'b000);
        wait_idle("t3_idle");
        check("t3_nframes", frames.size(), 4);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("t3_rise%0d", i), fr(i).rises, 16);
            check($sformatf("t3_len%0d", i), fr(i).len, 66);
            check($sformatf("t3_cmd%0d", i), fr(i).cmd, 8'h70);
        end
        check("t3_fsr", fsr_o, 8'h80);
        check("t3_done", ndone, 1);
        check("t3_err", error_o, 1'b0);

        // FSR never ready: timeout after four reads.
        resp = '{8'h00};
        clear_mon();
        start_seq(3'b000);
        wait_idle("t4_idle");
        check("t4_nframes", frames.size(), 5);
        check("t4_err", error_o, 1'b1);
        check("t4_done", ndone, 0);
        check("t4_fsr", fsr_o, 8'h00);
        start_seq(3'b000);
        check("t4_err_clr", error_o, 1'b0);
        abort_i = 1'b1;
        @(posedge clk);
        #1 abort_i = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
